risk_eval_scheduler: RTL and testbench
======================================

RISK_EVAL_SCHEDULER -- requirements
Module: risk_eval_scheduler

Interface
REQ-001 SHALL have parameters: NCH, default 4, number of sensor channels; PERSIST, default 3 (range 1..15), consecutive critical results before an alert; STALE_LIMIT, default 16'd1000, idle cycles before a channel is flagged stale.
REQ-002 SHALL have ports, in order:
  clk        in   1         single clock, rising edge;
  rst_n      in   1         asynchronous, active-low reset;
  in_valid   in   NCH       per-channel sample offered;
  in_ready   out  NCH       per-channel sample accepted;
  in_alt     in   NCH*16    altitude, channel i in bits [16i+15:16i];
  in_spd     in   NCH*16    speed, same packing;
  in_hdg     in   NCH*16    heading, same packing;
  res_valid  out  1         result available;
  res_ready  in   1         downstream accepts result;
  res_ch     out  2         channel of the result;
  res_risk   out  16        risk word;
  alert      out  NCH       sticky persistent-risk alert;
  alert_clr  in   NCH       per-channel alert clear, single-cycle pulse;
  stale      out  NCH       channel silent for at least STALE_LIMIT cycles;
  busy       out  1         high whenever the state is not IDLE.

Function
REQ-003 SHALL share one risk evaluator among NCH channels. The evaluator registers its risk word with 1-cycle latency. Flags: bit15 alt<0x0200; bit14 alt>0xF000; bit13 spd>0xC000; bit11 alt<0x0300; bit10 alt>0xEF00; bit9 spd>0xB800.
REQ-004 SHALL use the states IDLE, EVAL and RESP.
REQ-005 In IDLE with any in_valid set, in_ready SHALL be asserted combinationally for exactly one channel (the round-robin winner); the sample is captured and the state moves to EVAL.
REQ-006 In EVAL, the held sample SHALL drive the evaluator; next state is RESP.
REQ-007 In RESP, res_valid SHALL be 1 and res_ch/res_risk SHALL stay stable until res_valid&res_ready, after which the state returns to IDLE.
REQ-008 Latency from acceptance to res_valid SHALL be exactly 2 cycles; minimum spacing between acceptances SHALL be 3 cycles.
REQ-009 in_ready SHALL be all-zero outside IDLE; in_valid changes outside IDLE SHALL be ignored.
REQ-010 The round-robin pointer SHALL advance to the granted channel+1 (mod NCH) on each acceptance; a lone requester SHALL be granted every time it is in IDLE.
REQ-011 On each result handshake, the channel's 4-bit persistence counter SHALL increment (saturating at 15) if res_risk[15:13]!=0, and SHALL clear otherwise.
REQ-012 alert[ch] SHALL set when that counter reaches PERSIST.
REQ-013 alert[ch] SHALL stay set until alert_clr[ch]; alert_clr SHALL also zero the counter; if set and clear coincide, set SHALL win.

Reset
REQ-014 On rst_n low, all outputs SHALL go to 0 immediately: in_ready, res_valid, res_ch, res_risk, alert, stale and busy.
REQ-015 Reset SHALL also force state=IDLE, RR pointer=0 (channel 0 highest priority), and clear all counters.
REQ-016 A sample in flight at reset SHALL be discarded without producing a result.

Configuration
REQ-017 With SCHED_STALE_WATCHDOG_EN defined, each channel SHALL have a 16-bit saturating idle counter, cleared on acceptance from that channel; stale[ch]=(counter>=STALE_LIMIT).
REQ-018 Without SCHED_STALE_WATCHDOG_EN, the counters SHALL not exist and stale SHALL be tied to 0; the port SHALL remain.

Structure
REQ-019 A shared package risk_sched_pkg SHALL hold the state enum, the flag-mask constants (CRIT_MASK=16'hE000, WARN_MASK=16'h0E00) and the channel-index width.
REQ-020 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector + pointer in, one-hot grant out); the risk evaluator SHALL be instantiated once.

Verification
REQ-021 Ch1 alt=0x0100, spd=0x1000, res_ready=1 -> res_valid 2 cycles after acceptance, res_ch=1, res_risk=0x8800.
REQ-022 Ch0 alt=0x1000, spd=0xC100 -> res_risk=0x2200; hold res_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
REQ-023 All four in_valid held high for 12 acceptances -> grant order 0,1,2,3,0,1,2,3,... with one acceptance every 3 cycles.
REQ-024 Ch2 gives 3 consecutive alt=0x0100 results -> alert[2]=1 after the 3rd handshake; alert_clr[2] coinciding with a 4th critical result -> alert stays 1; a later clear with no result -> 0.
REQ-025 rst_n pulsed low during EVAL -> res_valid never rises for that sample, busy=0; with SCHED_STALE_WATCHDOG_EN, STALE_LIMIT=20 and ch3 idle -> stale[3]=1 from cycle 20 after reset.

Source files
------------

// File: rtl/risk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : risk_sched_pkg
// Brief   : Shared scheduler state type, risk flag masks and the flag function.
// Revision: 1.0 - initial release
// ============================================================================
package risk_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [15:0] CRIT_MASK = 16'hE000;
    localparam logic [15:0] WARN_MASK = 16'h0E00;
    localparam int          CH_W      = 2;

    function automatic logic [15:0] risk_flags(input logic [15:0] alt,
                                               input logic [15:0] spd);
        logic [15:0] f;
        f     = '0;
        f[15] = (alt < 16'h0200);
        f[14] = (alt > 16'hF000);
        f[13] = (spd > 16'hC000);
        f[11] = (alt < 16'h0300);
        f[10] = (alt > 16'hEF00);
        f[9]  = (spd > 16'hB800);
        return f & (CRIT_MASK | WARN_MASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risk_evaluator.sv
`default_nettype none
// ============================================================================
// Module  : risk_evaluator
// Brief   : Registered risk-flag evaluation of one altitude/speed sample.
// Revision: 1.0 - initial release
// ============================================================================
module risk_evaluator
    import risk_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] alt,
    input  logic [15:0] spd,
    output logic [15:0] risk
);

    logic [15:0] risk_q;
    logic [15:0] risk_d;

    always_comb begin
        risk_d = risk_q;
        if (en) risk_d = risk_flags(alt, spd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) risk_q <= '0;
        else        risk_q <= risk_d;
    end

    assign risk = risk_q;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin grant; channel at ptr has highest priority, then ptr+1...
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH   = 4,
    parameter int PTR_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NCH-1:0]   grant
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(ptr) + off) % NCH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/risk_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : risk_eval_scheduler
// Brief   : Shares one risk evaluator among NCH channels with persistence
//           alerts. Optional idle watchdog: SCHED_STALE_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module risk_eval_scheduler
    import risk_sched_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          PERSIST     = 3,
    parameter logic [15:0] STALE_LIMIT = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*16-1:0] in_alt,
    input  logic [NCH*16-1:0] in_spd,
    input  logic [NCH*16-1:0] in_hdg,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_ch,
    output logic [15:0]       res_risk,
    output logic [NCH-1:0]    alert,
    input  logic [NCH-1:0]    alert_clr,
    output logic [NCH-1:0]    stale,
    output logic              busy
);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [15:0]           alt_q, alt_d;
    logic [15:0]           spd_q, spd_d;
    logic [NCH-1:0][3:0]   pcnt_q, pcnt_d;
    logic [NCH-1:0]        alert_q, alert_d;
    logic [NCH-1:0]        grant;
    logic [CH_W-1:0]       grant_idx;
    logic [15:0]           risk;
    logic                  accept;
    logic                  res_hs;
    logic                  unused_hdg;

    // Heading is carried on the interface but contributes no risk flag.
    assign unused_hdg = ^in_hdg;

    rr_arbiter #(
        .NCH   (NCH),
        .PTR_W (CH_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    risk_evaluator u_eval (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_EVAL),
        .alt   (alt_q),
        .spd   (spd_q),
        .risk  (risk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EVAL;
            ST_EVAL:                state_d = ST_RESP;
            ST_RESP: if (res_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        in_ready  = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: if (rst_n) in_ready = grant;
            ST_EVAL: busy = 1'b1;
            ST_RESP: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept   = |in_ready;
    assign res_hs   = res_valid & res_ready;
    assign res_ch   = res_valid ? ch_q : '0;
    assign res_risk = res_valid ? risk : '0;
    assign alert    = alert_q;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NCH; i++)
            if (grant[i]) grant_idx = CH_W'(i);
    end

    always_comb begin
        ptr_d = ptr_q;
        ch_d  = ch_q;
        alt_d = alt_q;
        spd_d = spd_q;
        if (accept) begin
            ptr_d = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
            ch_d  = grant_idx;
            for (int i = 0; i < NCH; i++) begin
                if (grant[i]) begin
                    alt_d = in_alt[16*i +: 16];
                    spd_d = in_spd[16*i +: 16];
                end
            end
        end
    end

    // A result on a channel owns its counter that cycle; alert set beats clear.
    always_comb begin
        pcnt_d  = pcnt_q;
        alert_d = alert_q;
        for (int i = 0; i < NCH; i++) begin
            logic       hit;
            logic       crit;
            logic [3:0] sat;
            hit  = res_hs && (int'(ch_q) == i);
            crit = (risk & CRIT_MASK) != '0;
            sat  = (pcnt_q[i] == 4'hF) ? 4'hF : pcnt_q[i] + 4'd1;
            if (hit)               pcnt_d[i] = crit ? sat : 4'd0;
            else if (alert_clr[i]) pcnt_d[i] = 4'd0;
            if (hit && crit && (int'(sat) >= PERSIST)) alert_d[i] = 1'b1;
            else if (alert_clr[i])                     alert_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            ch_q    <= '0;
            alt_q   <= '0;
            spd_q   <= '0;
            pcnt_q  <= '0;
            alert_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            alt_q   <= alt_d;
            spd_q   <= spd_d;
            pcnt_q  <= pcnt_d;
            alert_q <= alert_d;
        end
    end

`ifdef SCHED_STALE_WATCHDOG_EN
    logic [NCH-1:0][15:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        for (int i = 0; i < NCH; i++) begin
            if (in_ready[i])                idle_d[i] = '0;
            else if (idle_q[i] != 16'hFFFF) idle_d[i] = idle_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_stale
        assign stale[g] = (idle_q[g] >= STALE_LIMIT);
    end
`else
    localparam logic [15:0] UNUSED_STALE_LIMIT = STALE_LIMIT;
    assign stale = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_risk_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_risk_eval_scheduler
// Brief   : Randomized self-checking bench with a behavioural scheduler model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_risk_eval_scheduler;

    localparam int          NCH         = 4;
    localparam int          PERSIST     = 3;
    localparam logic [15:0] STALE_LIMIT = 16'd20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH-1:0]    in_ready;
    logic [NCH*16-1:0] in_alt = '0;
    logic [NCH*16-1:0] in_spd = '0;
    logic [NCH*16-1:0] in_hdg = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [1:0]        res_ch;
    logic [15:0]       res_risk;
    logic [NCH-1:0]    alert;
    logic [NCH-1:0]    alert_clr = '0;
    logic [NCH-1:0]    stale;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int m_ptr;
    int m_cnt[NCH];
    bit m_alert[NCH];

    risk_eval_scheduler #(
        .NCH         (NCH),
        .PERSIST     (PERSIST),
        .STALE_LIMIT (STALE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_alt    (in_alt),
        .in_spd    (in_spd),
        .in_hdg    (in_hdg),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_risk  (res_risk),
        .alert     (alert),
        .alert_clr (alert_clr),
        .stale     (stale),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    function automatic logic [15:0] ref_risk(input logic [15:0] alt, input logic [15:0] spd);
        logic [15:0] r = 16'h0000;
        if (alt < 16'h0200) r = r + 16'h8000;
        if (alt > 16'hF000) r = r + 16'h4000;
        if (spd > 16'hC000) r = r + 16'h2000;
        if (alt < 16'h0300) r = r + 16'h0800;
        if (alt > 16'hEF00) r = r + 16'h0400;
        if (spd > 16'hB800) r = r + 16'h0200;
        return r;
    endfunction

    function automatic int ref_winner(input logic [NCH-1:0] v);
        for (int k = 0; k < NCH; k++)
            if (v[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        return -1;
    endfunction

    function automatic logic [NCH-1:0] onehot(input int c);
        logic [NCH-1:0] v = '0;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [NCH-1:0] alert_vec();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_alert[i];
        return v;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 16'h0400));
            1:       return 16'($urandom_range(16'hEE00, 16'hFFFF));
            2:       return 16'($urandom_range(16'hB700, 16'hC200));
            default: return 16'($urandom);
        endcase
    endfunction

    // Result handshake on channel ch (or none if ch<0) with clear pulses clr.
    task automatic model_handshake(input int ch, input logic [15:0] risk, input logic [NCH-1:0] clr);
        for (int i = 0; i < NCH; i++) begin
            bit crit_set = 0;
            if (i == ch) begin
                if (risk[15:13] != 3'b000) begin
                    m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
                    crit_set = (m_cnt[i] >= PERSIST);
                end else begin
                    m_cnt[i] = 0;
                end
            end else if (clr[i]) begin
                m_cnt[i] = 0;
            end
            if (crit_set)    m_alert[i] = 1;
            else if (clr[i]) m_alert[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]   = 0;
            m_alert[i] = 0;
        end
    endtask

    task automatic set_ch(input int ch, input logic [15:0] a, input logic [15:0] s);
        in_alt[16*ch +: 16] = a;
        in_spd[16*ch +: 16] = s;
        in_hdg[16*ch +: 16] = 16'($urandom);
    endtask

    task automatic apply_reset();
        in_valid  = '0;
        alert_clr = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One lone-requester transaction, clr driven on the handshake cycle.
    task automatic run_one(input int ch, input logic [15:0] a, input logic [15:0] s,
                           input logic [NCH-1:0] clr);
        int n = 0;
        @(negedge clk);
        set_ch(ch, a, s);
        in_valid  = onehot(ch);
        res_ready = 1'b1;
        @(negedge clk);
        in_valid = '0;
        m_ptr    = (ch + 1) % NCH;
        while (res_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) begin
            checks++; errors++;
            $display("FAIL run_one_timeout: res_valid=%b after %0d cycles, required 1", res_valid, n);
        end
        alert_clr = clr;
        model_handshake(ch, ref_risk(a, s), clr);
        @(negedge clk);
        alert_clr = '0;
    endtask

    task automatic test_reset();
        in_valid  = '1;
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b res_valid=%b busy=%b, required 0", in_ready, res_valid, busy);
        end
        checks++;
        if (res_ch !== 2'd0 || res_risk !== 16'h0 || alert !== '0 || stale !== '0) begin
            errors++;
            $display("FAIL reset_data: res_ch=%0d res_risk=%h alert=%b stale=%b, required 0", res_ch, res_risk, alert, stale);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int lat = 1;
        @(negedge clk);
        set_ch(1, 16'h0100, 16'h1000);
        in_valid  = 4'b0010;
        res_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: in_ready=%b, required 0010", in_ready);
        end
        @(negedge clk);
        in_valid = '0;
        m_ptr    = 2;
        while (res_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required 2", lat);
        end
        checks++;
        if (res_ch !== 2'd1 || res_risk !== ref_risk(16'h0100, 16'h1000) || res_risk !== 16'h8800) begin
            errors++;
            $display("FAIL single_result: ch=%0d risk=%h, required ch=1 risk=8800", res_ch, res_risk);
        end
        model_handshake(1, 16'h8800, '0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b res_valid=%b, required 0", busy, res_valid);
        end
    endtask

    task automatic test_hold();
        int n = 0;
        @(negedge clk);
        set_ch(0, 16'h1000, 16'hC100);
        in_valid  = 4'b0001;
        res_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL hold_grant: in_ready=%b, required 0001", in_ready);
        end
        m_ptr = 1;
        while (res_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            in_valid = 4'($urandom);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 4'($urandom) | 4'b0001;
            set_ch(0, pick(), pick());
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_risk !== 16'h2200 || in_ready !== '0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b ch=%0d risk=%h in_ready=%b, required 1/0/2200/0000",
                         k, res_valid, res_ch, res_risk, in_ready);
            end
        end
        in_valid  = '0;
        res_ready = 1'b1;
        model_handshake(0, 16'h2200, '0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: busy=%b res_valid=%b, required 0", busy, res_valid);
        end
    endtask

    task automatic test_round_robin();
        int          acc = 0;
        int          last = -1;
        int          cyc = 0;
        int          q_ch[$];
        logic [15:0] q_risk[$];
        apply_reset();
        res_ready = 1'b1;
        while (acc < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = '1;
            for (int i = 0; i < NCH; i++) set_ch(i, pick(), pick());
            #1;
            checks++;
            if (alert !== alert_vec()) begin
                errors++;
                $display("FAIL rr_alert: alert=%b, required %b", alert, alert_vec());
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (q_ch.size() == 0) begin
                    errors++;
                    $display("FAIL rr_spurious: result ch=%0d with none outstanding", res_ch);
                end else begin
                    if (res_ch !== 2'(q_ch[0]) || res_risk !== q_risk[0]) begin
                        errors++;
                        $display("FAIL rr_result: ch=%0d risk=%h, required ch=%0d risk=%h",
                                 res_ch, res_risk, q_ch[0], q_risk[0]);
                    end
                    model_handshake(q_ch[0], q_risk[0], '0);
                    void'(q_ch.pop_front());
                    void'(q_risk.pop_front());
                end
            end
            if (in_ready !== '0) begin
                int w;
                w = ref_winner(in_valid);
                checks++;
                if (in_ready !== onehot(w)) begin
                    errors++;
                    $display("FAIL rr_grant: in_ready=%b, required %b (acceptance %0d)", in_ready, onehot(w), acc);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL rr_spacing: %0d cycles, required 3", cyc - last);
                    end
                end
                last = cyc;
                q_ch.push_back(w);
                q_risk.push_back(ref_risk(in_alt[16*w +: 16], in_spd[16*w +: 16]));
                m_ptr = (w + 1) % NCH;
                acc++;
            end
        end
        checks++;
        if (acc != 12) begin
            errors++;
            $display("FAIL rr_count: %0d acceptances, required 12", acc);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = '0;
            #1;
            if (res_valid === 1'b1 && q_ch.size() != 0) begin
                checks++;
                if (res_ch !== 2'(q_ch[0]) || res_risk !== q_risk[0]) begin
                    errors++;
                    $display("FAIL rr_drain: ch=%0d risk=%h, required ch=%0d risk=%h",
                             res_ch, res_risk, q_ch[0], q_risk[0]);
                end
                model_handshake(q_ch[0], q_risk[0], '0);
                void'(q_ch.pop_front());
                void'(q_risk.pop_front());
            end
        end
        checks++;
        if (q_ch.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_leftover: %0d results outstanding busy=%b, required 0", q_ch.size(), busy);
        end
        checks++;
        if (alert !== alert_vec()) begin
            errors++;
            $display("FAIL rr_alert_end: alert=%b, required %b", alert, alert_vec());
        end
    endtask

    task automatic test_persist();
        apply_reset();
        repeat (3) run_one(2, 16'h0100, 16'h1000, '0);
        #1;
        checks++;
        if (alert !== 4'b0100 || alert !== alert_vec()) begin
            errors++;
            $display("FAIL persist_set: alert=%b, required 0100", alert);
        end
        run_one(2, 16'h0100, 16'h1000, 4'b0100);
        #1;
        checks++;
        if (alert !== 4'b0100) begin
            errors++;
            $display("FAIL persist_set_wins: alert=%b, required 0100", alert);
        end
        @(negedge clk);
        alert_clr = 4'b0100;
        model_handshake(-1, 16'h0, 4'b0100);
        @(negedge clk);
        alert_clr = '0;
        checks++;
        if (alert !== 4'b0000) begin
            errors++;
            $display("FAIL persist_clear: alert=%b, required 0000", alert);
        end
        repeat (2) run_one(2, 16'h0100, 16'h1000, '0);
        run_one(2, 16'h1000, 16'h1000, '0);
        run_one(2, 16'h1000, 16'hC800, '0);
        #1;
        checks++;
        if (alert !== 4'b0000 || alert !== alert_vec()) begin
            errors++;
            $display("FAIL persist_counter_zeroed: alert=%b, required 0000", alert);
        end
        repeat (2) run_one(2, 16'hF800, 16'h0000, '0);
        #1;
        checks++;
        if (alert !== 4'b0100 || alert !== alert_vec()) begin
            errors++;
            $display("FAIL persist_reset_again: alert=%b, required 0100", alert);
        end
    endtask

    task automatic test_inflight_reset();
        bit seen = 0;
        @(negedge clk);
        set_ch(3, 16'h0100, 16'h1000);
        in_valid  = 4'b1000;
        res_ready = 1'b1;
        @(negedge clk);
        in_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL inflight_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || alert !== '0) begin
            errors++;
            $display("FAIL inflight_reset: busy=%b res_valid=%b alert=%b, required 0", busy, res_valid, alert);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = 1;
`ifdef SCHED_STALE_WATCHDOG_EN
            if (k == 19 || k == 20) begin
                checks++;
                if (stale[3] !== (k >= 20)) begin
                    errors++;
                    $display("FAIL stale_cycle%0d: stale[3]=%b, required %b", k, stale[3], (k >= 20));
                end
            end
`else
            if (k == 25) begin
                checks++;
                if (stale !== '0) begin
                    errors++;
                    $display("FAIL stale_tied: stale=%b, required 0000", stale);
                end
            end
`endif
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL inflight_discard: result_seen=%0d busy=%b, required 0/0", seen, busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_hold();
        test_round_robin();
        test_persist();
        test_inflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
